if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction-fetch front end of the 5-stage RISC-V pipeline. Owns the PC register and the IF/ID pipeline register.
- Talks to instruction memory over a req/ready + rvalid handshake with variable latency and at most one request outstanding.
- Consumes the ID-stage stall controls (pcwrite, ifidwrite) and the EX-stage branch redirect.
- A one-entry hold buffer keeps an instruction that returns while ID is stalled, so it is not lost.

Parameters:
XLEN, 32, data/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-low reset
pcwrite  input  1  from hazard unit; 0 = hold PC
ifidwrite  input  1  from hazard unit; 0 = hold IF/ID register
flush_if  input  1  taken branch/jump resolved in EX; squash IF and ID
branch_target  input  XLEN  redirect PC, valid with flush_if
imem_req  output  1  fetch request
imem_addr  output  XLEN  fetch address (= pc)
imem_ready  input  1  request accepted this cycle when imem_req=1
imem_rvalid  input  1  read data valid (exactly one per accepted request)
imem_rdata  input  32  instruction word
pc_id  output  XLEN  IF/ID register: PC of instruction in ID
instr_id  output  32  IF/ID register: instruction in ID
valid_id  output  1  IF/ID register: 0 = bubble (decode as NOP)

Behaviour:
- Reset (rst=0, asynchronous):
  - pc=RESET_PC, state=REQ, hold buffer empty.
  - valid_id=0, instr_id=32'h0000_0013 (NOP), pc_id=0.
  - After release, the first cycle drives imem_req=1.
- advance = pcwrite & ifidwrite. Both are normally driven equal.
- imem_req = (state==REQ) & ~flush_if. imem_addr = pc at all times.
- FSM states: REQ, WAIT, HOLD, DROP.
  - REQ: on imem_req & imem_ready → WAIT.
  - WAIT, imem_rvalid with advance=1:
    - IF/ID loads {pc, imem_rdata, valid=1}; pc ← pc+4; → REQ.
    - Zero-bubble path: the same-cycle rvalid reaches IF/ID at the next edge.
  - WAIT, imem_rvalid with advance=0: rdata and pc captured into the hold buffer; → HOLD.
  - HOLD: on advance=1, IF/ID loads the buffer with valid=1; pc ← pc+4; → REQ.
- IF/ID when no instruction is delivered:
  - ifidwrite=1: valid_id ← 0 (bubble).
  - ifidwrite=0: IF/ID holds its value.
- Flush (flush_if=1) has priority over stall and over data return:
  - valid_id ← 0; instr_id ← NOP; pc ← branch_target; hold buffer discarded.
  - REQ: no request is issued that cycle; stay REQ, next request uses branch_target.
  - WAIT with imem_rvalid the same cycle: data discarded; → REQ.
  - WAIT without imem_rvalid: → DROP.
  - HOLD: → REQ.
  - DROP: stay DROP; pc updated to the newest target.
- DROP: waits for the in-flight response, discards it, then → REQ. No new request while in DROP.
- PC arithmetic: pc+4 modulo 2^XLEN (wraps 0xFFFF_FFFC → 0). Low two bits are carried as-is; there is no misalignment check.
- Protocol rules:
  - imem_rvalid arriving in REQ or HOLD is a protocol error; the block ignores it.
  - Never more than one outstanding request.
- Reset mid-transaction: all state is cleared immediately. The memory side is reset by the same rst, so no stale response arrives.

Test Plan:
- Reset then 1-cycle memory (ready=1, rvalid the cycle after accept), pcwrite=ifidwrite=1 → imem_addr 0,4,8,…; pc_id/instr_id follow each fetched word; valid_id=1 from the first return.
- Load-use stall: pcwrite=ifidwrite=0 for 2 cycles while rvalid returns instr at pc 0x10 → state HOLD, IF/ID unchanged, no new imem_req. After release, pc_id=0x10 with the buffered instr, next request 0x14.
- Flush in WAIT (latency 3, flush_if at cycle 1 of wait, branch_target=0x100) → valid_id=0 next cycle; the old response is discarded (DROP); next request addr=0x100; no instruction from the old path reaches ID.
- Flush and stall in the same cycle, plus flush coincident with rvalid → flush wins; valid_id=0, pc=target, data dropped, state REQ.
- PC wrap: RESET_PC=0xFFFF_FFF8 → requests 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
- Assert rst low while in WAIT → outputs return to reset values immediately; after release imem_req=1 with addr=RESET_PC.

Source files
------------

// File: rtl/if_fetch_unit.sv
// ----------------------------------------------------------------------------
// if_fetch_unit
// Instruction-fetch front end of the 5-stage pipeline. Owns the PC and the
// IF/ID pipeline register, fetches from instruction memory over a req/ready +
// rvalid handshake (one request outstanding at most), honours ID-stage stalls
// and EX-stage redirects, and parks a word that returns during a stall in a
// one-entry hold buffer.
//
// Ports
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   pcwrite           0 = hold PC (hazard unit)
//   ifidwrite         0 = hold IF/ID register (hazard unit)
//   flush_if          taken branch/jump resolved in EX; squash IF and ID
//   branch_target     redirect PC, valid with flush_if
//   imem_req          fetch request (combinational from state and flush_if)
//   imem_addr         fetch address, always equal to the PC
//   imem_ready        request accepted this cycle when imem_req=1
//   imem_rvalid       read data valid, one per accepted request
//   imem_rdata        instruction word
//   pc_id, instr_id   IF/ID register: PC and instruction in ID
//   valid_id          IF/ID register: 0 = bubble
// ----------------------------------------------------------------------------
module if_fetch_unit #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = {XLEN{1'b0}}
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pcwrite,
  input  logic            ifidwrite,
  input  logic            flush_if,
  input  logic [XLEN-1:0] branch_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic [XLEN-1:0] pc_id,
  output logic [31:0]     instr_id,
  output logic            valid_id
);

  localparam int unsigned     ILEN = 32;
  localparam logic [ILEN-1:0] NOP  = 32'h0000_0013;

  // REQ: may issue; WAIT: response pending; HOLD: word parked during stall;
  // DROP: response pending but belongs to a squashed path
  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2,
    S_DROP = 2'd3
  } state_t;

  state_t          state;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] hold_pc;
  logic [ILEN-1:0] hold_instr;
  logic            advance;

  assign advance   = pcwrite & ifidwrite;
  assign pc_plus4  = pc + XLEN'(4);
  assign imem_req  = (state == S_REQ) & ~flush_if;
  assign imem_addr = pc;

  // PC, fetch FSM, hold buffer and IF/ID register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= S_REQ;
      pc         <= RESET_PC;
      hold_pc    <= {XLEN{1'b0}};
      hold_instr <= NOP;
      pc_id      <= {XLEN{1'b0}};
      instr_id   <= NOP;
      valid_id   <= 1'b0;
    end else if (flush_if) begin
      // Redirect wins over stall and data return; the hold buffer is
      // abandoned by leaving HOLD.
      valid_id <= 1'b0;
      instr_id <= NOP;
      pc       <= branch_target;
      case (state)
        // An in-flight response must still be absorbed before re-issuing
        S_WAIT, S_DROP: state <= imem_rvalid ? S_REQ : S_DROP;
        default:        state <= S_REQ;
      endcase
    end else begin
      // Bubble unless an instruction is delivered below
      if (ifidwrite) begin
        valid_id <= 1'b0;
      end
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (advance) begin
              pc_id    <= pc;
              instr_id <= imem_rdata;
              valid_id <= 1'b1;
              pc       <= pc_plus4;
              state    <= S_REQ;
            end else begin
              hold_pc    <= pc;
              hold_instr <= imem_rdata;
              state      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          // Stray rvalid here is a protocol error and is ignored
          if (advance) begin
            pc_id    <= hold_pc;
            instr_id <= hold_instr;
            valid_id <= 1'b1;
            pc       <= pc_plus4;
            state    <= S_REQ;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state <= S_REQ;
          end
        end
        default: state <= S_REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed vector table, reset-in-WAIT sequence and
// randomized traffic against a transaction-level reference model.
module tb_if_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] A0  = 32'hA0A0_0001;
  localparam logic [31:0] A1  = 32'hA1A1_0002;
  localparam logic [31:0] A2  = 32'hA2A2_0003;

  logic        clk = 1'b0;
  logic        rst;
  logic        pcwrite, ifidwrite, flush_if;
  logic [31:0] branch_target;
  logic        imem_ready, imem_rvalid;
  logic [31:0] imem_rdata;

  logic        imem_req, w_req;
  logic [31:0] imem_addr, w_addr;
  logic [31:0] pc_id, w_pc_id;
  logic [31:0] instr_id, w_instr_id;
  logic        valid_id, w_valid_id;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  if_fetch_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .pcwrite(pcwrite), .ifidwrite(ifidwrite),
    .flush_if(flush_if), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_id(pc_id), .instr_id(instr_id), .valid_id(valid_id)
  );

  // Same stimulus, reset PC near the top of the address space
  if_fetch_unit #(.XLEN(32), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .pcwrite(pcwrite), .ifidwrite(ifidwrite),
    .flush_if(flush_if), .branch_target(branch_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_ready(imem_ready),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .pc_id(w_pc_id), .instr_id(w_instr_id), .valid_id(w_valid_id)
  );

  // ---------------- reference model (transaction level) ----------------
  logic [31:0] m_pc;
  logic        m_out;        // a request is in flight
  logic        m_drop;       // in-flight response belongs to a squashed path
  logic        m_buf;        // a word is parked
  logic [31:0] m_buf_pc, m_buf_instr;
  logic        m_vid;
  logic [31:0] m_iid, m_pid;
  logic        m_req;

  // memory timing generator
  logic        mem_busy;
  int          mem_cnt;

  task automatic model_reset();
    m_pc = 32'h0; m_out = 1'b0; m_drop = 1'b0; m_buf = 1'b0;
    m_buf_pc = 32'h0; m_buf_instr = 32'h0;
    m_vid = 1'b0; m_iid = NOP; m_pid = 32'h0;
    mem_busy = 1'b0; mem_cnt = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%08h, expected 0x%08h", name, $time, act, exp);
    end
  endtask

  task automatic drive_check(input logic pcw, input logic ifw, input logic fl,
                             input logic [31:0] tgt, input logic rdy,
                             input logic rv, input logic [31:0] rd);
    @(negedge clk);
    pcwrite = pcw; ifidwrite = ifw; flush_if = fl; branch_target = tgt;
    imem_ready = rdy; imem_rvalid = rv; imem_rdata = rd;
    #1;
    m_req = !m_out && !m_buf && !fl;
    chk("model imem_req", 32'(imem_req), 32'(m_req));
    chk("model imem_addr", imem_addr, m_pc);
    chk("model valid_id", 32'(valid_id), 32'(m_vid));
    chk("model instr_id", instr_id, m_iid);
    chk("model pc_id", pc_id, m_pid);
  endtask

  // Applies the clock edge that follows drive_check to the model
  task automatic model_update(output logic acc);
    logic        deliver;
    logic [31:0] d_pc, d_instr;
    deliver = 1'b0; d_pc = 32'h0; d_instr = 32'h0;
    acc = m_req & imem_ready;
    if (flush_if) begin
      m_vid = 1'b0; m_iid = NOP; m_pc = branch_target; m_buf = 1'b0;
      if (m_out) begin
        if (imem_rvalid) begin m_out = 1'b0; m_drop = 1'b0; end
        else m_drop = 1'b1;
      end
    end else begin
      if (acc) begin
        m_out = 1'b1; m_drop = 1'b0;
      end else if (m_out && imem_rvalid) begin
        m_out = 1'b0;
        if (m_drop) m_drop = 1'b0;
        else if (pcwrite && ifidwrite) begin
          deliver = 1'b1; d_pc = m_pc; d_instr = imem_rdata;
        end else begin
          m_buf = 1'b1; m_buf_pc = m_pc; m_buf_instr = imem_rdata;
        end
      end else if (m_buf && pcwrite && ifidwrite) begin
        deliver = 1'b1; d_pc = m_buf_pc; d_instr = m_buf_instr; m_buf = 1'b0;
      end
      if (deliver) begin
        m_vid = 1'b1; m_iid = d_instr; m_pid = d_pc; m_pc = d_pc + 32'd4;
      end else if (ifidwrite) begin
        m_vid = 1'b0;
      end
    end
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    pcwrite = 1'b0; ifidwrite = 1'b0; flush_if = 1'b0; branch_target = 32'h0;
    imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    @(negedge clk); @(negedge clk); #1;
    chk("reset imem_req", 32'(imem_req), 32'd1);
    chk("reset imem_addr", imem_addr, 32'h0);
    chk("reset valid_id", 32'(valid_id), 32'd0);
    chk("reset instr_id", instr_id, NOP);
    chk("reset pc_id", pc_id, 32'h0);
    chk("reset wrap imem_addr", w_addr, 32'hFFFF_FFF8);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        pcw, ifw, fl;
    logic [31:0] tgt;
    logic        rdy, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr, e_waddr;
    logic        e_valid;
    logic [31:0] e_instr, e_pcid;
  } vec_t;

  vec_t tbl [17];

  initial begin
    logic acc;
    logic pcw, ifw, fl, rv, rdy;
    logic [31:0] tgt, rd;

    // fetch with 1-cycle memory, stall with data return, flushes
    tbl[0]  = '{1,1,0,32'h0,  1,0,32'h0,        1,32'h0,  32'hFFFF_FFF8,0,NOP,32'h0};
    tbl[1]  = '{1,1,0,32'h0,  1,1,A0,           0,32'h0,  32'hFFFF_FFF8,0,NOP,32'h0};
    tbl[2]  = '{1,1,0,32'h0,  1,0,32'h0,        1,32'h4,  32'hFFFF_FFFC,1,A0, 32'h0};
    tbl[3]  = '{1,1,0,32'h0,  1,1,A1,           0,32'h4,  32'hFFFF_FFFC,0,A0, 32'h0};
    tbl[4]  = '{1,1,0,32'h0,  1,0,32'h0,        1,32'h8,  32'h0,        1,A1, 32'h4};
    tbl[5]  = '{0,0,0,32'h0,  1,1,A2,           0,32'h8,  32'h0,        0,A1, 32'h4};
    tbl[6]  = '{0,0,0,32'h0,  1,0,32'h0,        0,32'h8,  32'h0,        0,A1, 32'h4};
    tbl[7]  = '{1,1,0,32'h0,  1,0,32'h0,        0,32'h8,  32'h0,        0,A1, 32'h4};
    tbl[8]  = '{1,1,0,32'h0,  1,0,32'h0,        1,32'hC,  32'h4,        1,A2, 32'h8};
    tbl[9]  = '{1,1,1,32'h100,1,0,32'h0,        0,32'hC,  32'h4,        0,A2, 32'h8};
    tbl[10] = '{1,1,0,32'h0,  1,0,32'h0,        0,32'h100,32'h100,      0,NOP,32'h8};
    tbl[11] = '{1,1,0,32'h0,  1,1,32'hDEAD_BEEF,0,32'h100,32'h100,      0,NOP,32'h8};
    tbl[12] = '{1,1,0,32'h0,  0,0,32'h0,        1,32'h100,32'h100,      0,NOP,32'h8};
    tbl[13] = '{1,1,1,32'h200,1,0,32'h0,        0,32'h100,32'h100,      0,NOP,32'h8};
    tbl[14] = '{1,1,0,32'h0,  1,0,32'h0,        1,32'h200,32'h200,      0,NOP,32'h8};
    tbl[15] = '{0,0,1,32'h300,1,1,32'hBAD0_0BAD,0,32'h200,32'h200,      0,NOP,32'h8};
    tbl[16] = '{1,1,0,32'h0,  0,0,32'h0,        1,32'h300,32'h300,      0,NOP,32'h8};

    apply_reset();
    for (int i = 0; i < 17; i++) begin
      drive_check(tbl[i].pcw, tbl[i].ifw, tbl[i].fl, tbl[i].tgt,
                  tbl[i].rdy, tbl[i].rv, tbl[i].rdata);
      chk($sformatf("vec%0d imem_req", i), 32'(imem_req), 32'(tbl[i].e_req));
      chk($sformatf("vec%0d imem_addr", i), imem_addr, tbl[i].e_addr);
      chk($sformatf("vec%0d wrap_addr", i), w_addr, tbl[i].e_waddr);
      chk($sformatf("vec%0d valid_id", i), 32'(valid_id), 32'(tbl[i].e_valid));
      chk($sformatf("vec%0d instr_id", i), instr_id, tbl[i].e_instr);
      chk($sformatf("vec%0d pc_id", i), pc_id, tbl[i].e_pcid);
      model_update(acc);
    end

    // ---------------- randomized traffic ----------------
    apply_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      pcw = ($urandom_range(0, 3) != 0);
      ifw = pcw;
      if ($urandom_range(0, 15) == 0) ifw = ~pcw;
      fl  = ($urandom_range(0, 9) == 0);
      tgt = $urandom;
      rdy = 1'($urandom_range(0, 1));
      rd  = $urandom;
      // stray rvalid when nothing is in flight exercises the ignore path
      rv  = mem_busy ? (mem_cnt == 1) : ($urandom_range(0, 19) == 0);
      drive_check(pcw, ifw, fl, tgt, rdy, rv, rd);
      model_update(acc);
      if (mem_busy) begin
        if (mem_cnt == 1) mem_busy = 1'b0;
        else mem_cnt--;
      end
      if (acc) begin
        mem_busy = 1'b1;
        mem_cnt  = int'($urandom_range(1, 3));
      end
    end

    // ---------------- reset asserted while in WAIT ----------------
    apply_reset();
    drive_check(1, 1, 0, 32'h0, 1, 0, 32'h0);  model_update(acc);
    drive_check(1, 1, 0, 32'h0, 0, 1, A0);     model_update(acc);
    drive_check(0, 0, 0, 32'h0, 1, 0, 32'h0);  model_update(acc);  // accept under stall
    @(negedge clk); #1;
    imem_ready = 1'b0; imem_rvalid = 1'b0;
    chk("pre-reset valid_id", 32'(valid_id), 32'd1);
    chk("pre-reset imem_req", 32'(imem_req), 32'd0);
    rst = 1'b0;
    #1;
    chk("midreset imem_req", 32'(imem_req), 32'd1);
    chk("midreset imem_addr", imem_addr, 32'h0);
    chk("midreset wrap_addr", w_addr, 32'hFFFF_FFF8);
    chk("midreset valid_id", 32'(valid_id), 32'd0);
    chk("midreset instr_id", instr_id, NOP);
    chk("midreset pc_id", pc_id, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    drive_check(1, 1, 0, 32'h0, 1, 0, 32'h0);  model_update(acc);
    drive_check(1, 1, 0, 32'h0, 0, 1, A1);     model_update(acc);
    drive_check(1, 1, 0, 32'h0, 0, 0, 32'h0);  model_update(acc);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
